rx_axis_frame_fifo: RTL and testbench
=====================================

RX_AXIS_FRAME_FIFO -- requirements
Module: rx_axis_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, giving a buffer depth of 2^DEPTH_LOG2 beats.
REQ-002 SHALL have port clk156, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port rx_axis_aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports s_axis_tdata (in, 64), s_axis_tkeep (in, 8), s_axis_tvalid (in, 1), s_axis_tlast (in, 1) and s_axis_tuser (in, 1): the MAC receive stream, which has no tready; tuser is sampled with tlast, 1 = good frame.
REQ-005 SHALL have ports m_axis_tdata (out, 64), m_axis_tkeep (out, 8), m_axis_tvalid (out, 1), m_axis_tlast (out, 1) and m_axis_tready (in, 1): the downstream stream, carrying good frames only.
REQ-006 SHALL have ports good_frames, bad_frames and ovf_frames (out, 32 each): saturating event counters.
REQ-007 SHALL have port fifo_level (out, DEPTH_LOG2+1): wr_ptr minus rd_ptr.

Function
REQ-008 SHALL store {tlast, tkeep, tdata} (73 bits) per accepted beat; pointers wr_ptr, wr_commit and rd_ptr are DEPTH_LOG2+1 bits wide, with the MSB used as the wrap bit.
REQ-009 SHALL treat the buffer as full when wr_ptr − rd_ptr = 2^DEPTH_LOG2, and as empty-for-read when rd_ptr = wr_commit.
REQ-010 SHALL implement write FSM states SYNC, ACCEPT and DROP.
REQ-011 In SYNC, SHALL discard beats without counting them; a beat with tvalid & tlast SHALL move the FSM to ACCEPT.
REQ-012 In ACCEPT, a tvalid beat with the buffer not full SHALL be written at wr_ptr, and wr_ptr SHALL increment.
REQ-013 In ACCEPT, a written beat with tlast & tuser SHALL set wr_commit to the new wr_ptr and increment good_frames.
REQ-014 In ACCEPT, a written beat with tlast & !tuser SHALL set wr_ptr to wr_commit (rewind) and increment bad_frames.
REQ-015 In ACCEPT, a tvalid beat while full SHALL set wr_ptr to wr_commit and not write the beat.
  - If that beat has tlast: increment ovf_frames and stay in ACCEPT.
  - Otherwise: go to DROP.
  - Full takes priority over tuser; the frame counts as ovf only.
REQ-016 In DROP, SHALL discard beats; a tvalid & tlast beat SHALL increment ovf_frames and return the FSM to ACCEPT.
REQ-017 Partial (uncommitted) frames SHALL never be visible on m_axis.
REQ-018 m_axis_tvalid SHALL assert 2 cycles after the commit edge when the output path is idle.
REQ-019 SHALL sustain 1 beat/cycle while m_axis_tready=1 and committed data exists.
REQ-020 While m_axis_tvalid & !m_axis_tready, all m_axis outputs SHALL hold stable.
REQ-021 rd_ptr SHALL advance on RAM read; rewinds SHALL never touch rd_ptr or wr_commit.
REQ-022 Simultaneous write and read of the same RAM address SHALL be impossible: reads are gated by wr_commit.
REQ-023 Counters SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-024 Pointer wrap from 2^(DEPTH_LOG2+1)−1 to 0 SHALL be seamless.

Reset
REQ-025 While rx_axis_aresetn=0 at an edge, SHALL set:
  - FSM to SYNC;
  - all pointers to 0;
  - all counters to 0;
  - m_axis_tvalid to 0.
  - m_axis_tdata, tkeep and tlast SHALL read 0.
REQ-026 Reset mid-frame SHALL discard all stored data; the next frame is accepted only after the first tlast seen in SYNC.

Structure
REQ-027 Package rx_fifo_pkg SHALL hold the DEPTH_LOG2 default, the entry width constant (73) and the write FSM state encoding.
REQ-028 SHALL instantiate one sub-module, rx_fifo_ram: simple dual-port, 73-bit wide, 1-cycle registered read. Output buffering (skid/prefetch) SHALL live in the top level.

Verification
REQ-029 Scenario 1: after reset, a 3-beat frame with tuser=0 followed by a 4-beat good frame.
  - Response: the first frame is swallowed by SYNC and not counted.
  - The 4-beat good frame is output intact with tkeep preserved; good_frames=1.
REQ-030 Scenario 2: a 5-beat frame with tuser=0 on tlast.
  - Response: nothing appears on m_axis; bad_frames=1; wr_ptr equals its pre-frame value.
REQ-031 Scenario 3: DEPTH_LOG2=4, m_axis_tready=0, a 20-beat frame.
  - Response: ovf_frames=1, fifo_level=0, m_axis_tvalid=0.
  - A following 8-beat good frame passes.
REQ-032 Scenario 4: back-to-back 64-byte good frames with m_axis_tready toggling 1/0 each cycle.
  - Response: every beat is delivered once, in order, with data held stable while stalled.
REQ-033 Scenario 5: the buffer becomes exactly full on the tlast beat of a good frame.
  - Response: the frame is committed (full is hit after the write); the next frame's first beat triggers DROP.
REQ-034 Scenario 6: reset asserted at beat 3 of a 6-beat frame.
  - Response: all counters=0 and m_axis_tvalid=0.
  - Remaining beats are discarded; the next complete good frame passes.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// Shared constants, write-FSM encoding and counter helper for the
// receive frame FIFO. Ports: none (package).
package rx_fifo_pkg;

    localparam int DEPTH_LOG2_DEF = 9;
    localparam int ENTRY_W        = 73;

    typedef enum logic [1:0] {
        WR_SYNC   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_DROP   = 2'd2
    } wr_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rx_axis_frame_fifo_if.sv
// AXI-Stream bundle (tdata/tkeep/tvalid/tlast/tuser/tready).
// Ports: none; modports master (drives beats) and slave (drives tready).
interface rx_axis_frame_fifo_if;

    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/rx_fifo_ram.sv
// Simple dual-port RAM, one write port, one read port, 1-cycle
// registered read. Ports: clk156, we/waddr/wdata, re/raddr/rdata.
module rx_fifo_ram
    import rx_fifo_pkg::*;
#(
    parameter int AW = DEPTH_LOG2_DEF,
    parameter int W  = ENTRY_W
) (
    input  logic          clk156,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk156) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rx_axis_frame_fifo.sv
// Store-and-forward RX frame FIFO: buffers MAC beats, commits good frames,
// rewinds bad/overflowed ones. Ports: clk156, rx_axis_aresetn, s_axis_*
// (no tready), m_axis_*, good/bad/ovf_frames counters, fifo_level.
module rx_axis_frame_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk156,
    input  logic                  rx_axis_aresetn,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           good_frames,
    output logic [31:0]           bad_frames,
    output logic [31:0]           ovf_frames,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    wr_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
    logic r_vld_q, r_vld_d;
    logic m_vld_q, m_vld_d;
    logic [ENTRY_W-1:0] m_ent_q, m_ent_d;
    logic [ENTRY_W-1:0] rdata;
    logic we, re, full, avail, out_rdy;

    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH;
    assign avail   = rd_ptr_q != wr_commit_q;
    assign out_rdy = !m_vld_q || m_axis_tready;
    // Read only into a free RAM output stage; gating on wr_commit keeps
    // reads away from the region still being written.
    assign re      = avail && (!r_vld_q || out_rdy);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        good_d      = good_q;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        we          = 1'b0;
        unique case (state_q)
            WR_SYNC: begin
                if (s_axis_tvalid && s_axis_tlast) state_d = WR_ACCEPT;
            end
            WR_ACCEPT: begin
                if (s_axis_tvalid && full) begin
                    // Overflow beats the tuser verdict.
                    wr_ptr_d = wr_commit_q;
                    if (s_axis_tlast) ovf_d = sat_inc(ovf_q);
                    else state_d = WR_DROP;
                end else if (s_axis_tvalid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (s_axis_tlast && s_axis_tuser) begin
                        wr_commit_d = wr_ptr_q + ONE;
                        good_d      = sat_inc(good_q);
                    end else if (s_axis_tlast) begin
                        wr_ptr_d = wr_commit_q;
                        bad_d    = sat_inc(bad_q);
                    end
                end
            end
            WR_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    ovf_d   = sat_inc(ovf_q);
                    state_d = WR_ACCEPT;
                end
            end
            default: state_d = WR_SYNC;
        endcase
    end

    // Two-stage output: RAM read register, then the m_axis register.
    always_comb begin
        rd_ptr_d = re ? rd_ptr_q + ONE : rd_ptr_q;
        r_vld_d  = re || (r_vld_q && !out_rdy);
        m_vld_d  = m_vld_q;
        m_ent_d  = m_ent_q;
        if (out_rdy) begin
            m_vld_d = r_vld_q;
            if (r_vld_q) m_ent_d = rdata;
        end
    end

    always_ff @(posedge clk156) begin
        if (!rx_axis_aresetn) begin
            state_q     <= WR_SYNC;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
            r_vld_q     <= 1'b0;
            m_vld_q     <= 1'b0;
            m_ent_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            r_vld_q     <= r_vld_d;
            m_vld_q     <= m_vld_d;
            m_ent_q     <= m_ent_d;
        end
    end

    rx_fifo_ram #(
        .AW (DEPTH_LOG2),
        .W  (ENTRY_W)
    ) u_ram (
        .clk156 (clk156),
        .we     (we),
        .waddr  (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata  ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .re     (re),
        .raddr  (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata  (rdata)
    );

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_ent_q[72];
    assign m_axis_tkeep  = m_ent_q[71:64];
    assign m_axis_tdata  = m_ent_q[63:0];
    assign good_frames   = good_q;
    assign bad_frames    = bad_q;
    assign ovf_frames    = ovf_q;
    assign fifo_level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_rx_axis_frame_fifo.sv
// Scoreboard bench for rx_axis_frame_fifo: directed scenarios plus a
// randomized phase, checked against a frame-level reference model.
module tb_rx_axis_frame_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic clk156 = 1'b0;
    logic rst_n  = 1'b0;
    logic [31:0] good_frames, bad_frames, ovf_frames;
    logic [DL:0] fifo_level;

    rx_axis_frame_fifo_if s_if ();
    rx_axis_frame_fifo_if m_if ();

    beat_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int exp_ovf = 0;
    bit synced = 1'b0;
    int rdy_mode = 1;

    always #5 clk156 = ~clk156;

    rx_axis_frame_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk156          (clk156),
        .rx_axis_aresetn (rst_n),
        .s_axis_tdata    (s_if.tdata),
        .s_axis_tkeep    (s_if.tkeep),
        .s_axis_tvalid   (s_if.tvalid),
        .s_axis_tlast    (s_if.tlast),
        .s_axis_tuser    (s_if.tuser),
        .m_axis_tdata    (m_if.tdata),
        .m_axis_tkeep    (m_if.tkeep),
        .m_axis_tvalid   (m_if.tvalid),
        .m_axis_tlast    (m_if.tlast),
        .m_axis_tready   (m_if.tready),
        .good_frames     (good_frames),
        .bad_frames      (bad_frames),
        .ovf_frames      (ovf_frames),
        .fifo_level      (fifo_level)
    );

    task automatic chk(input string name, input logic [72:0] act,
                       input logic [72:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready pattern: 0 low, 1 high, 2 toggle, 3 random.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            case (rdy_mode)
                0: m_if.tready = 1'b0;
                1: m_if.tready = 1'b1;
                2: m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected beats on handshake, checks hold on stall.
    initial begin
        beat_t got;
        beat_t held;
        beat_t exp;
        bit stall;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk156);
            got = {m_if.tdata, m_if.tkeep, m_if.tlast};
            if (stall) begin
                chk("hold_valid", 73'(m_if.tvalid), 73'(1));
                chk("hold_data", got, held);
            end
            stall = m_if.tvalid && !m_if.tready;
            held = got;
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", got);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", got, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'($urandom_range(0, 1));
        s_if.tdata  = {$urandom, $urandom};
        repeat (n) begin
            @(posedge clk156);
            #1;
        end
    endtask

    task automatic put(input beat_t b, input bit user);
        s_if.tvalid = 1'b1;
        s_if.tdata  = b.d;
        s_if.tkeep  = b.k;
        s_if.tlast  = b.l;
        s_if.tuser  = user;
        @(posedge clk156);
        #1;
    endtask

    function automatic beat_t rnd_beat(input bit last);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.k = last ? 8'($urandom_range(1, 255)) : 8'hFF;
        b.l = last;
        return b;
    endfunction

    // Frame fate from the model: unsynced frames vanish, overflowed frames
    // count as ovf only, otherwise tuser on the last beat decides.
    task automatic send_frame(input int len, input bit user,
                              input bit ovf, input bit bubbles);
        beat_t fr[$];
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (bubbles)
                while ($urandom_range(0, 3) == 0) idle(1);
            b = rnd_beat(i == len - 1);
            fr.push_back(b);
            put(b, (i == len - 1) ? user : 1'($urandom_range(0, 1)));
        end
        if (!synced) synced = 1'b1;
        else if (ovf) exp_ovf++;
        else if (user) begin
            exp_good++;
            foreach (fr[j]) sb.push_back(fr[j]);
        end else exp_bad++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || m_if.tvalid || fifo_level != 0) && t < 500) begin
            idle(1);
            t++;
        end
        chk("drain_timeout", 73'(t < 500), 73'(1));
        idle(2);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_good"}, 73'(good_frames), 73'(exp_good));
        chk({tag, "_bad"}, 73'(bad_frames), 73'(exp_bad));
        chk({tag, "_ovf"}, 73'(ovf_frames), 73'(exp_ovf));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int t;
        bit user;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tdata  = '0;
        repeat (3) @(posedge clk156);
        #1;
        chk_cnt("reset");
        chk("reset_tvalid", 73'(m_if.tvalid), 73'(0));
        chk("reset_out", {m_if.tdata, m_if.tkeep, m_if.tlast}, 73'(0));
        chk("reset_level", 73'(fifo_level), 73'(0));
        rst_n = 1'b1;
        idle(2);

        // Sync swallow, then a good frame.
        send_frame(3, 1'b0, 1'b0, 1'b0);
        send_frame(4, 1'b1, 1'b0, 1'b0);
        drain();
        chk_cnt("s1");

        // Bad frame is rewound.
        send_frame(5, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("s2_level", 73'(fifo_level), 73'(0));
        chk("s2_tvalid", 73'(m_if.tvalid), 73'(0));
        drain();
        chk_cnt("s2");

        // Oversized frame while stalled.
        rdy_mode = 0;
        send_frame(20, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("s3_ovf", 73'(ovf_frames), 73'(exp_ovf));
        chk("s3_level", 73'(fifo_level), 73'(0));
        chk("s3_tvalid", 73'(m_if.tvalid), 73'(0));
        send_frame(8, 1'b1, 1'b0, 1'b0);
        idle(4);
        rdy_mode = 1;
        drain();
        chk_cnt("s3");

        // Back-to-back 64-byte frames with toggling ready.
        rdy_mode = 2;
        send_frame(8, 1'b1, 1'b0, 1'b0);
        send_frame(8, 1'b1, 1'b0, 1'b0);
        drain();
        rdy_mode = 1;
        chk_cnt("s4");

        // Exactly full on tlast; the next frame overflows.
        rdy_mode = 0;
        idle(2);
        send_frame(DEPTH, 1'b1, 1'b0, 1'b0);
        send_frame(3, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk_cnt("s5a");
        rdy_mode = 1;
        drain();
        chk_cnt("s5b");

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) put(rnd_beat(1'b0), 1'b1);
        rst_n = 1'b0;
        put(rnd_beat(1'b0), 1'b1);
        exp_good = 0;
        exp_bad = 0;
        exp_ovf = 0;
        synced = 1'b0;
        sb.delete();
        chk_cnt("s6_rst");
        chk("s6_tvalid", 73'(m_if.tvalid), 73'(0));
        chk("s6_level", 73'(fifo_level), 73'(0));
        put(rnd_beat(1'b0), 1'b1);
        rst_n = 1'b1;
        put(rnd_beat(1'b1), 1'b1);
        synced = 1'b1;
        idle(2);
        send_frame(6, 1'b1, 1'b0, 1'b0);
        drain();
        chk_cnt("s6");

        // Random frames, admitted only when they cannot overflow.
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            user = ($urandom_range(0, 3) != 0);
            t = 0;
            while (sb.size() + len > DEPTH && t < 500) begin
                idle(1);
                t++;
            end
            chk("rnd_space", 73'(t < 500), 73'(1));
            send_frame(len, user, 1'b0, 1'b1);
            idle($urandom_range(0, 3));
        end
        rdy_mode = 1;
        drain();
        chk_cnt("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
